// File: rtl/aes_pkg.sv
// Shared AES decryption constants, FSM state encoding and the inverse S-box lookup.
// Optional build macro used by the controller: AES_INV_ABORT_EN.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned STATE_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARK0,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } fsm_e;

    // Entry 0 sits in the most significant byte of the concatenation.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_inv_round_step.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last_round is set, InvMixColumns. Byte 0 is at [127:120], column-major.
module aes_inv_round_step
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [STATE_W-1:0] round_key,
    input  logic               last_round,
    output logic [STATE_W-1:0] state_out
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
        x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [STATE_W-1:0] aes_inv_mixcolumns(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
            r[119 - 32*c -: 8] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
            r[111 - 32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
            r[103 - 32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
        end
        return r;
    endfunction

    logic [STATE_W-1:0] ark;

    // Row r is rotated right by r: output (r,c) takes input (r,(c-r) mod 4).
    always_comb begin
        ark = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            ark[127 - 8*i -: 8] =
                inv_sbox(state_in[127 - 8*((((i/4) + 4 - (i%4)) % 4)*4 + (i%4)) -: 8])
                ^ round_key[127 - 8*i -: 8];
        end
    end

    assign state_out = last_round ? ark : aes_inv_mixcolumns(ark);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption controller: FSM, round counter, state register, handshakes.
// Build macro AES_INV_ABORT_EN adds an abort input that returns the engine to IDLE.
module aes_inv_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = aes_pkg::NR,
    parameter int unsigned RK_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               keys_valid,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    output logic [RK_AW-1:0]   rk_addr,
    input  logic [127:0]       rk_data,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef AES_INV_ABORT_EN
    input  logic               abort,
`endif
    output logic [127:0]       out_data,
    output logic               busy,
    output logic [RK_AW-1:0]   round
);

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_round_ctrl supports only NR = 10");
    end

    fsm_e               fsm;
    logic [STATE_W-1:0] st_q;
    logic [STATE_W-1:0] step_out;
    logic               abort_hit;

    aes_inv_round_step u_step (
        .state_in   (st_q),
        .round_key  (rk_data),
        .last_round (fsm == ST_FINAL),
        .state_out  (step_out)
    );

`ifdef AES_INV_ABORT_EN
    assign abort_hit = abort && (fsm != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= ST_IDLE;
            st_q  <= '0;
            round <= '0;
        end else if (abort_hit) begin
            fsm   <= ST_IDLE;
            round <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid && keys_valid) begin
                        st_q  <= in_data;
                        round <= RK_AW'(NR);
                        fsm   <= ST_ARK0;
                    end
                end
                ST_ARK0: begin
                    st_q  <= st_q ^ rk_data;
                    round <= RK_AW'(NR - 1);
                    fsm   <= ST_ROUND;
                end
                ST_ROUND: begin
                    st_q  <= step_out;
                    round <= round - 1'b1;
                    if (round == RK_AW'(1))
                        fsm <= ST_FINAL;
                end
                ST_FINAL: begin
                    st_q <= step_out;
                    fsm  <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        fsm <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // Key for the next cycle is requested one cycle early to cover the read latency.
    always_comb begin
        rk_addr = RK_AW'(NR);
        if (fsm == ST_ARK0 || fsm == ST_ROUND)
            rk_addr = round - 1'b1;
    end

    assign in_ready  = !rst && (fsm == ST_IDLE) && keys_valid;
    assign out_valid = (fsm == ST_DONE);
    assign busy      = (fsm != ST_IDLE);
    assign out_data  = st_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using the FIPS-197 C.1 AES-128 vector.
module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         rst, keys_valid, in_valid, out_ready;
    logic         in_ready, out_valid, busy;
    logic [127:0] in_data, rk_data, out_data;
    logic [3:0]   rk_addr, round;
`ifdef AES_INV_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    aes_inv_round_ctrl #(.NR(10), .RK_AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .keys_valid (keys_valid),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef AES_INV_ABORT_EN
        .abort      (abort),
`endif
        .out_data   (out_data),
        .busy       (busy),
        .round      (round)
    );

    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic [127:0] rk_mem [0:15];
    always @(posedge clk) rk_data <= rk_mem[rk_addr];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string nm);
        int cnt;
        in_data  = CT;
        in_valid = 1'b1;
        cnt = 0;
        #1;
        while (!in_ready && cnt < 20) begin
            step();
            cnt++;
        end
        chk({nm, "_accept_ready"}, 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        chk({nm, "_latency"}, 128'(cnt), 128'(12));
        chk({nm, "_data"}, out_data, PT);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic       in_valid;
        logic       chk_addr;
        logic [3:0] rk_addr;
        logic       busy;
        logic       out_valid;
        logic       in_ready;
        logic       chk_round;
        logic [3:0] round;
    } vec_t;

    vec_t tv [13];

    initial begin
        int cyc, acc_n, out_n, seen;
        int acc_t [2];

        // FIPS-197 C.1 key schedule for key 000102..0f, indexed by round.
        for (int i = 0; i < 16; i++) rk_mem[i] = '0;
        rk_mem[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_mem[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_mem[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_mem[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_mem[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_mem[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_mem[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_mem[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_mem[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_mem[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_mem[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        // Per-cycle expectations, offset k from the accept cycle T.
        tv[0]  = '{1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
        tv[1]  = '{1'b0, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tv[2]  = '{1'b0, 1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 4'd9};
        tv[3]  = '{1'b0, 1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b1, 4'd8};
        tv[4]  = '{1'b0, 1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 4'd7};
        tv[5]  = '{1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 4'd6};
        tv[6]  = '{1'b0, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b1, 4'd5};
        tv[7]  = '{1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd4};
        tv[8]  = '{1'b0, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3};
        tv[9]  = '{1'b0, 1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
        tv[10] = '{1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
        tv[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tv[12] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0};

        rst = 1'b1; keys_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef AES_INV_ABORT_EN
        abort = 1'b0;
`endif
        step();
        step();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_round", 128'(round), 128'(0));
        chk("rst_rk_addr", 128'(rk_addr), 128'(10));
        chk("rst_out_data", out_data, 128'(0));

        // Cycle-by-cycle walk through one block with out_ready held low.
        in_data = CT;
        for (int k = 0; k < 13; k++) begin
            in_valid = tv[k].in_valid;
            #1;
            if (tv[k].chk_addr) chk($sformatf("seq_rk_addr_%0d", k), 128'(rk_addr), 128'(tv[k].rk_addr));
            chk($sformatf("seq_busy_%0d", k), 128'(busy), 128'(tv[k].busy));
            chk($sformatf("seq_out_valid_%0d", k), 128'(out_valid), 128'(tv[k].out_valid));
            chk($sformatf("seq_in_ready_%0d", k), 128'(in_ready), 128'(tv[k].in_ready));
            if (tv[k].chk_round) chk($sformatf("seq_round_%0d", k), 128'(round), 128'(tv[k].round));
            if (k == 12) chk("seq_out_data", out_data, PT);
            step();
        end

        // Back-pressure: DONE holds for 20 cycles, new input ignored.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'(1));
            chk($sformatf("bp_out_data_%0d", i), out_data, PT);
            chk($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'(0));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("bp_release_busy", 128'(busy), 128'(0));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));

        // keys_valid gates acceptance in IDLE.
        keys_valid = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("kv_in_ready_%0d", i), 128'(in_ready), 128'(0));
            step();
            chk($sformatf("kv_busy_%0d", i), 128'(busy), 128'(0));
        end
        keys_valid = 1'b1;
        #1;
        chk("kv_raise_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        chk("kv_accepted", 128'(busy), 128'(1));
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk("kv_latency", 128'(cyc), 128'(12));
        chk("kv_data", out_data, PT);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Back-to-back blocks with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cyc = 0; acc_n = 0; out_n = 0;
        acc_t[0] = 0; acc_t[1] = 0;
        while (out_n < 2 && cyc < 100) begin
            #1;
            if (in_valid && in_ready && acc_n < 2) begin
                acc_t[acc_n] = cyc;
                acc_n++;
            end
            if (out_valid) begin
                chk($sformatf("b2b_data_%0d", out_n), out_data, PT);
                out_n++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_outputs", 128'(out_n), 128'(2));
        chk("b2b_accept_gap", 128'(acc_t[1] - acc_t[0]), 128'(13));
        step();

        // Reset during round processing discards the block.
        in_data  = CT;
        in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_round", 128'(round), 128'(0));
        chk("mid_rst_rk_addr", 128'(rk_addr), 128'(10));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("mid_rst_no_output", 128'(seen), 128'(0));
        run_block("after_rst");

`ifdef AES_INV_ABORT_EN
        // Abort at the same point behaves like the reset case.
        in_data  = CT;
        in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_round", 128'(round), 128'(0));
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("abort_no_output", 128'(seen), 128'(0));
        run_block("after_abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
Iterative AES-128 decryption engine controller. Accepts one 128-bit ciphertext block over a valid/ready handshake. Fetches round keys 10..0 from the round-key store over a synchronous read port. Sequences the inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, aes_inv_mixcolumns), one round per clock, and returns the plaintext over a valid/ready handshake. Sits between the block-cipher front end and the key-expansion RAM.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails for any other value.
RK_AW, 4, round-key address width.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
keys_valid  in  1  round-key store holds a complete schedule.
in_valid  in  1  ciphertext valid.
in_ready  out  1  engine can accept a ciphertext.
in_data  in  128  ciphertext; byte 0 is at [127:120], column-major.
rk_addr  out  RK_AW  round-key read address.
rk_data  in  128  round key; read latency is 1 cycle.
out_valid  out  1  plaintext valid.
out_ready  in  1  downstream accepts the plaintext.
out_data  out  128  plaintext.
busy  out  1  high in every state except IDLE.
round  out  RK_AW  current round index, for debug.

Behaviour:
- Reset (synchronous, active-high). On reset:
  - state goes to IDLE;
  - in_ready=0 during reset;
  - out_valid=0, out_data=0, busy=0, round=0, rk_addr=NR;
  - the internal state register is cleared.
- FSM states: IDLE, ARK0, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = keys_valid; rk_addr = 10.
  - Accept occurs when in_valid & in_ready. At accept cycle T, the state register takes in_data and the FSM moves to ARK0.
- ARK0 (T+1):
  - state <= state ^ rk_data (rk_data is key 10).
  - rk_addr = 9; round <= 9; go to ROUND.
- ROUND (T+2..T+10, round 9 down to 1):
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - rk_addr = round-1; round decrements.
  - When round==1, the next state is FINAL.
- FINAL (T+11):
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk_data (key 0, no InvMixColumns).
  - Go to DONE.
- DONE (T+12 onward):
  - out_valid=1; out_data holds the state register.
  - out_data and out_valid stay stable until out_ready is sampled high. Then return to IDLE next cycle.
- Latency: exactly 12 cycles from accept to out_valid. Throughput is one block per 13 cycles with out_ready tied high.
- in_ready=0 in every state other than IDLE. in_valid asserted while busy is ignored and not queued.
- keys_valid is sampled only in IDLE. Deassertion mid-block does not stop the current block.
- out_ready while not in DONE is ignored.
- rst mid-operation discards the block; out_valid is never asserted for it.
- rk_addr is a combinational function of FSM state and round. It never exceeds 10.

Optional Feature:
AES_INV_ABORT_EN:
- Defined: adds input port abort (1 bit). When abort is high in any non-IDLE state, the FSM goes to IDLE on the next edge. out_valid is deasserted, busy drops, and round is cleared. abort in IDLE has no effect. If abort and out_ready are both high in DONE, the result is treated as aborted.
- Undefined: no abort port; behaviour is as above.

Decomposition:
- Package aes_pkg holds:
  - NR, the ST_IDLE..ST_DONE state encodings;
  - the AES state width constant (128);
  - inverse S-box table function.
- Sub-module aes_inv_round_step (combinational) holds InvShiftRows → InvSubBytes → AddRoundKey → optional aes_inv_mixcolumns, selected by input last_round.
- The controller keeps only the FSM, round counter, state register and handshakes.

Test Plan:
- FIPS-197 C.1 vector, key 000102…0f loaded in the key model, in_data=69c4e0d86a7b0430d8cdb78070b4c55a → out_valid exactly 12 cycles after accept, out_data=00112233445566778899aabbccddeeff.
- Address sequence check → rk_addr is 10,9,8,…,1,0 on cycles T..T+10.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE → out_data/out_valid stable and in_ready=0 throughout. Raise out_ready → IDLE next cycle.
- keys_valid=0 with in_valid=1 → in_ready=0 and no accept. Raise keys_valid → accept on that cycle.
- Two back-to-back FIPS-197 blocks with out_ready=1 → accepts 13 cycles apart, both outputs correct.
- rst at T+6 → next cycle in IDLE, busy=0, no out_valid. A following block decrypts correctly. With AES_INV_ABORT_EN, abort at T+6 gives the same result.
